// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing RAM port A between two requesters, with a
// registered issue stage and a tagged read-response pipeline.
module bram_port_arbiter #(
   parameter int unsigned DATA_WIDTH   = 18,
   parameter int unsigned ADDR_WIDTH   = 10,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                  clka,
   input  logic                  rstb,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   output logic                  ram_regce,
   output logic                  ram_rst,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   logic                  last;
   logic                  grant0;
   logic                  grant1;
   logic                  hs;
   logic                  hs_id;
   logic                  hs_we;
   logic [ADDR_WIDTH-1:0] hs_addr;
   logic [DATA_WIDTH-1:0] hs_wdata;
   logic                  pipe_v  [READ_LATENCY];
   logic                  pipe_id [READ_LATENCY];
   logic                  rsp_v_q;
   logic                  rsp_id_q;

   // Grant goes to the requester that did not win most recently when both ask.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rstb) begin
         if (req0_valid && (!req1_valid || last)) begin
            grant0 = 1'b1;
         end else if (req1_valid) begin
            grant1 = 1'b1;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign hs         = grant0 | grant1;
   assign hs_id      = grant1;
   assign hs_we      = grant1 ? req1_we    : req0_we;
   assign hs_addr    = grant1 ? req1_addr  : req0_addr;
   assign hs_wdata   = grant1 ? req1_wdata : req0_wdata;

   always_ff @(posedge clka) begin
      if (rstb) begin
         last     <= 1'b1;
         ram_en   <= 1'b0;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
         rsp_v_q  <= 1'b0;
         rsp_id_q <= 1'b0;
         for (int i = 0; i < int'(READ_LATENCY); i++) begin
            pipe_v[i]  <= 1'b0;
            pipe_id[i] <= 1'b0;
         end
      end else begin
         if (hs) begin
            last     <= hs_id;
            ram_addr <= hs_addr;
            ram_din  <= hs_wdata;
         end
         ram_en     <= hs;
         ram_we     <= hs & hs_we;
         pipe_v[0]  <= hs & ~hs_we;
         pipe_id[0] <= hs_id;
         for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe_v[i]  <= pipe_v[i-1];
            pipe_id[i] <= pipe_id[i-1];
         end
         // Final stage lines up with the cycle ram_dout carries the read word.
         rsp_v_q  <= pipe_v[READ_LATENCY-1];
         rsp_id_q <= pipe_id[READ_LATENCY-1];
      end
   end

   generate
      if (READ_LATENCY > 1) begin : g_regce
         assign ram_regce = pipe_v[READ_LATENCY-1] & ~rstb;
      end else begin : g_no_regce
         assign ram_regce = 1'b0;
      end
   endgenerate

   assign rsp0_valid = rsp_v_q & ~rsp_id_q & ~rstb;
   assign rsp1_valid = rsp_v_q &  rsp_id_q & ~rstb;
   assign rsp0_rdata = ram_dout;
   assign rsp1_rdata = ram_dout;
   assign ram_rst    = rstb;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Drives two arbiter instances (READ_LATENCY 1 and 2) with identical requests,
// each backed by its own behavioural RAM, and scoreboards both against a model.
module tb_bram_port_arbiter;

   localparam int unsigned DW = 18;
   localparam int unsigned AW = 10;

   typedef struct {
      int          due;
      bit          id;
      logic [DW-1:0] data;
   } rsp_t;

   logic clka = 1'b0;
   always #5 clka = ~clka;

   logic          rstb;
   logic          req0_valid, req0_we, req1_valid, req1_we;
   logic [AW-1:0] req0_addr, req1_addr;
   logic [DW-1:0] req0_wdata, req1_wdata;

   logic          a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid;
   logic [DW-1:0] a_rsp0_rdata, a_rsp1_rdata, a_ram_din, a_dout;
   logic          a_ram_en, a_ram_we, a_ram_regce, a_ram_rst;
   logic [AW-1:0] a_ram_addr;
   logic          b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
   logic [DW-1:0] b_rsp0_rdata, b_rsp1_rdata, b_ram_din, b_lat, b_dout;
   logic          b_ram_en, b_ram_we, b_ram_regce, b_ram_rst;
   logic [AW-1:0] b_ram_addr;

   bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_a (
      .clka(clka), .rstb(rstb),
      .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp0_valid(a_rsp0_valid), .rsp0_rdata(a_rsp0_rdata),
      .rsp1_valid(a_rsp1_valid), .rsp1_rdata(a_rsp1_rdata),
      .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_din(a_ram_din),
      .ram_regce(a_ram_regce), .ram_rst(a_ram_rst), .ram_dout(a_dout));

   bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_b (
      .clka(clka), .rstb(rstb),
      .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
      .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
      .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_din(b_ram_din),
      .ram_regce(b_ram_regce), .ram_rst(b_ram_rst), .ram_dout(b_dout));

   function automatic logic [DW-1:0] init_val(input int unsigned i);
      return DW'((i * 32'd2654435761) >> 9);
   endfunction

   // Behavioural no-change RAMs; b has the optional output register.
   logic [DW-1:0] mem_a [1024];
   logic [DW-1:0] mem_b [1024];
   bit            pre_done = 1'b0;
   always @(posedge clka) begin
      if (!pre_done) begin
         for (int i = 0; i < 1024; i++) begin
            mem_a[i] <= init_val(i);
            mem_b[i] <= init_val(i);
         end
         pre_done <= 1'b1;
      end
      if (a_ram_rst) a_dout <= '0;
      else if (a_ram_en) begin
         if (a_ram_we) mem_a[a_ram_addr] <= a_ram_din;
         else          a_dout <= mem_a[a_ram_addr];
      end
      if (b_ram_en) begin
         if (b_ram_we) mem_b[b_ram_addr] <= b_ram_din;
         else          b_lat <= mem_b[b_ram_addr];
      end
      if (b_ram_rst)        b_dout <= '0;
      else if (b_ram_regce) b_dout <= b_lat;
   end

   int cyc = 0;
   always @(posedge clka) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model state, owned by the monitor.
   logic [DW-1:0] ref_mem [1024];
   bit            ref_init = 1'b0;
   bit            last_id = 1'b1;
   bit            exp_en = 1'b0, exp_we = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_din = '0;
   rsp_t          sb [2][$];
   bit            granted0 = 1'b0, granted1 = 1'b0;
   bit            grant_log [$];

   always @(negedge clka) begin
      bit   g0, g1, exp_v, regce_exp, rv0, rv1;
      rsp_t e;
      logic [DW-1:0] rd [2];
      if (!ref_init) begin
         for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
         ref_init = 1'b1;
      end
      g0 = !rstb && req0_valid && (!req1_valid || last_id);
      g1 = !rstb && req1_valid && !g0;
      chk("ready0_lat1", 32'(a_req0_ready), 32'(g0));
      chk("ready1_lat1", 32'(a_req1_ready), 32'(g1));
      chk("ready0_lat2", 32'(b_req0_ready), 32'(g0));
      chk("ready1_lat2", 32'(b_req1_ready), 32'(g1));
      chk("ram_rst_lat1", 32'(a_ram_rst), 32'(rstb));
      chk("ram_rst_lat2", 32'(b_ram_rst), 32'(rstb));
      chk("regce_lat1", 32'(a_ram_regce), 32'd0);

      if (rstb) begin
         for (int d = 0; d < 2; d++)
            while (sb[d].size() != 0 && sb[d][sb[d].size()-1].due >= cyc) void'(sb[d].pop_back());
      end else begin
         chk("ram_en_lat1", 32'(a_ram_en), 32'(exp_en));
         chk("ram_en_lat2", 32'(b_ram_en), 32'(exp_en));
         chk("ram_addr_lat1", 32'(a_ram_addr), 32'(exp_addr));
         chk("ram_addr_lat2", 32'(b_ram_addr), 32'(exp_addr));
         chk("ram_din_lat1", 32'(a_ram_din), 32'(exp_din));
         chk("ram_din_lat2", 32'(b_ram_din), 32'(exp_din));
         if (exp_en) begin
            chk("ram_we_lat1", 32'(a_ram_we), 32'(exp_we));
            chk("ram_we_lat2", 32'(b_ram_we), 32'(exp_we));
         end
         regce_exp = 1'b0;
         foreach (sb[1][i]) if (sb[1][i].due == cyc + 1) regce_exp = 1'b1;
         chk("regce_lat2", 32'(b_ram_regce), 32'(regce_exp));
      end

      for (int d = 0; d < 2; d++) begin
         exp_v = 1'b0;
         e = '{due: 0, id: 1'b0, data: '0};
         if (sb[d].size() != 0 && sb[d][0].due <= cyc) begin
            e = sb[d].pop_front();
            exp_v = (e.due == cyc);
         end
         rv0   = (d == 0) ? a_rsp0_valid : b_rsp0_valid;
         rv1   = (d == 0) ? a_rsp1_valid : b_rsp1_valid;
         rd[0] = (d == 0) ? a_rsp0_rdata : b_rsp0_rdata;
         rd[1] = (d == 0) ? a_rsp1_rdata : b_rsp1_rdata;
         chk($sformatf("rsp0_valid_lat%0d", d + 1), 32'(rv0), 32'(exp_v && !e.id));
         chk($sformatf("rsp1_valid_lat%0d", d + 1), 32'(rv1), 32'(exp_v && e.id));
         if (exp_v) chk($sformatf("rsp%0d_rdata_lat%0d", e.id, d + 1), 32'(rd[e.id]), 32'(e.data));
      end

      granted0 = a_req0_ready;
      granted1 = a_req1_ready;
      if (a_req0_ready || a_req1_ready) grant_log.push_back(a_req1_ready);

      if (rstb) begin
         last_id = 1'b1; exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_din = '0;
      end else if (g0 || g1) begin
         exp_en   = 1'b1;
         exp_we   = g1 ? req1_we : req0_we;
         exp_addr = g1 ? req1_addr : req0_addr;
         exp_din  = g1 ? req1_wdata : req0_wdata;
         last_id  = g1;
         if (exp_we) ref_mem[exp_addr] = exp_din;
         else begin
            sb[0].push_back('{due: cyc + 2, id: g1, data: ref_mem[exp_addr]});
            sb[1].push_back('{due: cyc + 3, id: g1, data: ref_mem[exp_addr]});
         end
      end else begin
         exp_en = 1'b0; exp_we = 1'b0;
      end
   end

   task automatic step();
      @(posedge clka);
      #2;
   endtask

   task automatic idle(input int n);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      int log_start;
      rstb = 1'b1;
      req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
      repeat (3) step();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      @(negedge clka);
      chk("rst_ram_en", 32'({a_ram_en, b_ram_en}), 32'd0);
      chk("rst_ram_we", 32'({a_ram_we, b_ram_we}), 32'd0);
      chk("rst_ram_addr", 32'({a_ram_addr, b_ram_addr}), 32'd0);
      chk("rst_ram_din", 32'({a_ram_din, b_ram_din}), 32'd0);
      chk("rst_regce", 32'({a_ram_regce, b_ram_regce}), 32'd0);
      chk("rst_ready", 32'({a_req0_ready, a_req1_ready, b_req0_ready, b_req1_ready}), 32'd0);
      chk("rst_ram_rst", 32'({a_ram_rst, b_ram_rst}), 32'd3);

      // Write then read-back from req0.
      step();
      rstb = 1'b0;
      req1_valid = 1'b0;
      req0_we = 1'b1; req0_addr = 10'h005; req0_wdata = 18'h2A5A5;
      step();
      req0_we = 1'b0;
      step();
      idle(5);

      // Single read from req1 at the top address (preloaded word).
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 10'h3FF;
      step();
      idle(5);

      // Sustained contention: grants must alternate starting with req0.
      log_start = grant_log.size();
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h001;
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 10'h002;
      repeat (6) step();
      idle(6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("alt_grant_%0d", i),
             32'((log_start + i < grant_log.size()) ? 32'(grant_log[log_start + i]) : 32'hDEAD),
             32'(i % 2));

      // Cross-requester write-then-read ordering.
      req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 10'h009; req1_wdata = 18'h00077;
      step();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h009;
      step();
      idle(6);

      // Randomised traffic; a pending request is held until granted.
      for (int k = 0; k < 400; k++) begin
         if (!req0_valid || granted0) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_we    = 1'($urandom_range(0, 1));
            req0_addr  = AW'($urandom_range(0, 15));
            req0_wdata = DW'($urandom);
         end
         if (!req1_valid || granted1) begin
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_we    = 1'($urandom_range(0, 1));
            req1_addr  = AW'($urandom_range(0, 15));
            req1_wdata = DW'($urandom);
         end
         step();
      end
      idle(8);

      // Reset with reads in flight, then contention right after reset.
      req0_valid = 1'b1; req0_we = 1'b0;
      for (int k = 0; k < 3; k++) begin
         req0_addr = AW'(10 + k);
         step();
      end
      req0_valid = 1'b0;
      rstb = 1'b1;
      step();
      rstb = 1'b0;
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h004;
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 10'h008;
      @(negedge clka);
      chk("post_rst_first_grant0", 32'({a_req0_ready, b_req0_ready}), 32'd3);
      chk("post_rst_first_grant1", 32'({a_req1_ready, b_req1_ready}), 32'd0);
      step();
      idle(8);

      chk("sb_drain_lat1", 32'(sb[0].size()), 32'd0);
      chk("sb_drain_lat2", 32'(sb[1].size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester round-robin arbiter that shares port A of the team's true-dual-port block RAM between independent masters (e.g. the AXI-lite register bridge and a streaming capture engine). It accepts one read or write per cycle with a valid/ready handshake, drives the RAM port-A enable, write and address lines from a registered issue stage, and returns read data to the originating requester with a tagged one-cycle response pulse. The response delay matches both RAM output modes: 1-cycle "LOW_LATENCY" and 2-cycle "HIGH_PERFORMANCE".

## Interface
- DATA_WIDTH, 18, RAM word width
- ADDR_WIDTH, 10, RAM address width (depth 2**ADDR_WIDTH)
- READ_LATENCY, 1, RAM read latency: 1 = no output register, 2 = output register (uses regce)
- clka  in  1  clock, shared with RAM port A
- rstb  in  1  reset, synchronous, active-high
- reqN_valid  in  1  request N (N = 0,1) valid
- reqN_ready  out  1  request N granted this cycle
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_WIDTH  word address
- reqN_wdata  in  DATA_WIDTH  write data
- rspN_valid  out  1  read data for requester N valid (1-cycle pulse, no backpressure)
- rspN_rdata  out  DATA_WIDTH  read data (= ram_dout)
- ram_en  out  1  RAM port A enable
- ram_we  out  1  RAM port A write enable
- ram_addr  out  ADDR_WIDTH  RAM port A address
- ram_din  out  DATA_WIDTH  RAM port A write data
- ram_regce  out  1  RAM port A output register enable (tied 0 when READ_LATENCY=1)
- ram_rst  out  1  RAM port A output reset, equals rstb
- ram_dout  in  DATA_WIDTH  RAM port A read data

## Operation
- Arbitration:
  - Combinational.
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted most recently wins.
  - Pointer `last` updates only on a grant.
  - Reset sets `last` = 1, so req0 wins the first contention.
- reqN_ready = grant N. A handshake is valid & ready. At most one handshake per cycle.
- No request is refused while it is alone. A contended requester waits at most 1 cycle.
- Issue stage:
  - Registered.
  - On a handshake in cycle T, the next edge loads ram_en=1, ram_we=we, ram_addr, ram_din.
  - ram_en=0 in any cycle after a cycle with no handshake.
  - ram_addr and ram_din hold their last values when ram_en=0.
- Response pipeline:
  - Shift register of READ_LATENCY stages, each carrying {valid, id}.
  - Loaded with valid = (handshake & ~we) and id = granted N.
  - READ_LATENCY=2: ram_regce = stage-1 valid.
- rspN_valid = last-stage valid & (id==N). rspN_rdata = ram_dout for both N; data is meaningful only with valid.
- Writes produce no response. The RAM is no-change, so ram_dout holds across writes. The arbiter never relies on ram_dout during write cycles.
- Ordering: port A is strictly sequential. A read accepted after a write to the same address (from either requester) returns the new data. Responses return in acceptance order.
- Reset (rstb=1):
  - All outputs 0.
  - Pipeline valids cleared, `last` = 1.
  - reqN_ready is forced 0 during reset.
  - Reads in flight at reset are discarded: no rsp pulse appears after reset deasserts.
- Back-to-back reads from alternating requesters sustain 1 read/cycle throughput.

## Timing
- Handshake in cycle T. ram_en/ram_we/ram_addr/ram_din are high/valid in cycle T+1.
- READ_LATENCY=1: rspN_valid in cycle T+2.
- READ_LATENCY=2: ram_regce in cycle T+2, rspN_valid in cycle T+3.
- Read latency = READ_LATENCY+1 cycles from handshake. Write commits at the end of T+1.
- Reset values: reqN_ready=0, rspN_valid=0, rspN_rdata follows ram_dout, ram_en=0, ram_we=0, ram_addr=0, ram_din=0, ram_regce=0, ram_rst=1.
- First grant is possible in the first cycle with rstb=0.

## Test plan
- Reset, then req0 write addr 0x005 data 0x2A5A5 (T), then req0 read 0x005 (T+1), READ_LATENCY=1. Expect ram_en/ram_we=1 at T+1, ram_en=1/ram_we=0 at T+2, rsp0_valid=1 with rdata 0x2A5A5 at T+3, rsp1_valid stays 0.
- Both requesters hold valid reads for 6 cycles (req0 addr 1, req1 addr 2). Expect grants 0,1,0,1,0,1 and responses alternating rsp0/rsp1 with data of addr 1/addr 2, one per cycle.
- READ_LATENCY=2: req1 read addr 0x3FF (T). Expect ram_regce=1 at T+2, rsp1_valid=1 at T+3 with preloaded value, and no rsp1_valid at T+2.
- req1 writes 0x00077 to addr 9 at T. req0 reads addr 9 at T+1. Expect rsp0_rdata=0x00077 (write-then-read ordering across requesters).
- Issue 3 reads, then assert rstb for 1 cycle while they are in flight. Expect no rspN_valid after reset. With both requesters valid in the first cycle after reset, req0 is granted first.
